// File: rtl/br_com_queue.sv
// ---------------------------------------------------------------------------
// br_com_queue : in-order branch commit queue feeding BTB training.
//
// Decode allocates one entry per branch at the tail (program order). Execute
// resolves entries out of order by id. The ROB retires the oldest entry once
// it is resolved, and the queue then emits a one-cycle registered training
// pulse (pc_chg_com_, chg_taken_, com_addr, com_tar_addr) to the BTB.
//
// Ports
//   clk            : clock, rising edge
//   reset_         : asynchronous active-low reset
//   alloc_         : active-low allocate request, alloc_pc = branch PC
//   alloc_id       : id of the current tail entry (from tail pointer)
//   bq_full        : queue holds BQ_D entries
//   resolve_       : active-low resolve strobe for entry resolve_id
//   resolve_taken_ : active-low taken flag, resolve_tar = target
//   commit_        : active-low retire of the oldest branch
//   commit_ready   : head entry valid and resolved
//   flush_         : active-low discard of every entry
//   pc_chg_com_    : active-low BTB training strobe (registered)
//   chg_taken_     : active-low taken flag for the BTB (registered)
//   com_addr       : committed branch PC (registered, holds)
//   com_tar_addr   : committed branch target (registered, holds)
//
// Build option
//   BQ_TAKEN_ONLY_EN : when defined, not-taken commits still pop the queue
//                      but do not pulse pc_chg_com_; only taken branches
//                      train the BTB.
// ---------------------------------------------------------------------------
module br_com_queue #(
  parameter int ADDR = 32,
  parameter int BQ_D = 8,
  parameter int BQ   = 3
) (
  input  logic            clk,
  input  logic            reset_,
  input  logic            alloc_,
  input  logic [ADDR-1:0] alloc_pc,
  output logic [BQ-1:0]   alloc_id,
  output logic            bq_full,
  input  logic            resolve_,
  input  logic [BQ-1:0]   resolve_id,
  input  logic            resolve_taken_,
  input  logic [ADDR-1:0] resolve_tar,
  input  logic            commit_,
  output logic            commit_ready,
  input  logic            flush_,
  output logic            pc_chg_com_,
  output logic            chg_taken_,
  output logic [ADDR-1:0] com_addr,
  output logic [ADDR-1:0] com_tar_addr
);

  localparam logic [BQ:0]   DEPTH_C = (BQ+1)'(BQ_D);
  localparam logic [BQ:0]   CNT_ONE = (BQ+1)'(1);
  localparam logic [BQ-1:0] PTR_ONE = BQ'(1);

  // Per-entry state
  logic [BQ_D-1:0] r_valid;
  logic [BQ_D-1:0] r_res;
  logic [BQ_D-1:0] r_taken;
  logic [ADDR-1:0] r_pc  [BQ_D];
  logic [ADDR-1:0] r_tar [BQ_D];

  // Queue pointers
  logic [BQ-1:0] r_head;
  logic [BQ-1:0] r_tail;
  logic [BQ:0]   r_count;

  // Training outputs
  logic            r_pc_chg_com_;
  logic            r_chg_taken_;
  logic [ADDR-1:0] r_com_addr;
  logic [ADDR-1:0] r_com_tar_addr;

  logic          w_full;
  logic          w_commit_ready;
  logic          w_do_alloc;
  logic          w_do_resolve;
  logic          w_do_commit;
  logic          w_train;
  logic [BQ:0]   w_count_nxt;

  // Decode the accepted operations for this cycle from registered state.
  always_comb begin
    w_full         = (r_count == DEPTH_C);
    w_commit_ready = r_valid[r_head] & r_res[r_head];
    w_do_commit    = ~commit_ & w_commit_ready;
    // Flush overrides alloc/resolve but lets a same-cycle commit train.
    w_do_alloc     = ~alloc_ & ~w_full & flush_;
    w_do_resolve   = ~resolve_ & r_valid[resolve_id] & flush_;
`ifdef BQ_TAKEN_ONLY_EN
    w_train        = w_do_commit & r_taken[r_head];
`else
    w_train        = w_do_commit;
`endif
    case ({w_do_alloc, w_do_commit})
      2'b10:   w_count_nxt = r_count + CNT_ONE;
      2'b01:   w_count_nxt = r_count - CNT_ONE;
      default: w_count_nxt = r_count;
    endcase
  end

  // Entry storage: commit clears head, alloc fills tail, resolve updates.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_valid <= '0;
      r_res   <= '0;
      r_taken <= '0;
      for (int i = 0; i < BQ_D; i++) begin
        r_pc[i]  <= '0;
        r_tar[i] <= '0;
      end
    end else begin
      for (int i = 0; i < BQ_D; i++) begin
        if (!flush_) begin
          r_valid[i] <= 1'b0;
          r_res[i]   <= 1'b0;
        end else if (w_do_commit && (r_head == BQ'(i))) begin
          r_valid[i] <= 1'b0;
          r_res[i]   <= 1'b0;
        end else if (w_do_alloc && (r_tail == BQ'(i))) begin
          r_valid[i] <= 1'b1;
          r_res[i]   <= 1'b0;
          r_pc[i]    <= alloc_pc;
        end else if (w_do_resolve && (resolve_id == BQ'(i))) begin
          // Re-resolving an already resolved entry simply overwrites it.
          r_res[i]   <= 1'b1;
          r_taken[i] <= ~resolve_taken_;
          r_tar[i]   <= resolve_tar;
        end else begin
          r_valid[i] <= r_valid[i];
        end
      end
    end
  end

  // Head/tail pointers and occupancy count.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (!flush_) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_commit) begin
        r_head <= r_head + PTR_ONE;
      end else begin
        r_head <= r_head;
      end
      if (w_do_alloc) begin
        r_tail <= r_tail + PTR_ONE;
      end else begin
        r_tail <= r_tail;
      end
      r_count <= w_count_nxt;
    end
  end

  // One-cycle BTB training pulse; address outputs hold between pulses.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_pc_chg_com_  <= 1'b1;
      r_chg_taken_   <= 1'b1;
      r_com_addr     <= '0;
      r_com_tar_addr <= '0;
    end else if (w_train) begin
      r_pc_chg_com_  <= 1'b0;
      r_chg_taken_   <= ~r_taken[r_head];
      r_com_addr     <= r_pc[r_head];
      r_com_tar_addr <= r_tar[r_head];
    end else begin
      r_pc_chg_com_  <= 1'b1;
      r_chg_taken_   <= 1'b1;
    end
  end

  assign alloc_id     = r_tail;
  assign bq_full      = w_full;
  assign commit_ready = w_commit_ready;
  assign pc_chg_com_  = r_pc_chg_com_;
  assign chg_taken_   = r_chg_taken_;
  assign com_addr     = r_com_addr;
  assign com_tar_addr = r_com_tar_addr;

endmodule

// File: tb/tb_br_com_queue.sv
// ---------------------------------------------------------------------------
// tb_br_com_queue : self-checking bench for br_com_queue.
// A behavioural queue model predicts each cycle's outcome; accepted commits
// push the expected training record onto a scoreboard that is popped and
// compared when the registered pulse appears one cycle later.
// ---------------------------------------------------------------------------
module tb_br_com_queue;

  localparam int ADDR = 32;
  localparam int BQ_D = 8;
  localparam int BQ   = 3;

  logic            clk;
  logic            reset_;
  logic            alloc_;
  logic [ADDR-1:0] alloc_pc;
  logic [BQ-1:0]   alloc_id;
  logic            bq_full;
  logic            resolve_;
  logic [BQ-1:0]   resolve_id;
  logic            resolve_taken_;
  logic [ADDR-1:0] resolve_tar;
  logic            commit_;
  logic            commit_ready;
  logic            flush_;
  logic            pc_chg_com_;
  logic            chg_taken_;
  logic [ADDR-1:0] com_addr;
  logic [ADDR-1:0] com_tar_addr;

  br_com_queue #(.ADDR(ADDR), .BQ_D(BQ_D), .BQ(BQ)) u_dut (
    .clk            (clk),
    .reset_         (reset_),
    .alloc_         (alloc_),
    .alloc_pc       (alloc_pc),
    .alloc_id       (alloc_id),
    .bq_full        (bq_full),
    .resolve_       (resolve_),
    .resolve_id     (resolve_id),
    .resolve_taken_ (resolve_taken_),
    .resolve_tar    (resolve_tar),
    .commit_        (commit_),
    .commit_ready   (commit_ready),
    .flush_         (flush_),
    .pc_chg_com_    (pc_chg_com_),
    .chg_taken_     (chg_taken_),
    .com_addr       (com_addr),
    .com_tar_addr   (com_tar_addr)
  );

  typedef struct {
    logic            taken;
    logic [ADDR-1:0] pc;
    logic [ADDR-1:0] tar;
  } exp_t;

  exp_t sb_q[$];

  // Reference model state
  bit              m_valid [BQ_D];
  bit              m_res   [BQ_D];
  bit              m_taken [BQ_D];
  logic [ADDR-1:0] m_pc    [BQ_D];
  logic [ADDR-1:0] m_tar   [BQ_D];
  int              m_head;
  int              m_tail;
  int              m_count;
  logic [ADDR-1:0] m_com_addr;
  logic [ADDR-1:0] m_com_tar;

  int n_tests;
  int n_fail;

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < BQ_D; i++) begin
      m_valid[i] = 1'b0;
      m_res[i]   = 1'b0;
      m_taken[i] = 1'b0;
      m_pc[i]    = '0;
      m_tar[i]   = '0;
    end
    m_head     = 0;
    m_tail     = 0;
    m_count    = 0;
    m_com_addr = '0;
    m_com_tar  = '0;
    sb_q.delete();
  endtask

  task automatic drive_idle();
    alloc_         = 1'b1;
    alloc_pc       = '0;
    resolve_       = 1'b1;
    resolve_id     = '0;
    resolve_taken_ = 1'b1;
    resolve_tar    = '0;
    commit_        = 1'b1;
    flush_         = 1'b1;
  endtask

  // One clock cycle: drive, predict, check pre-edge state and post-edge pulse.
  task automatic step(input bit a, input logic [ADDR-1:0] apc,
                      input bit r, input int rid, input bit rt, input logic [ADDR-1:0] rtar,
                      input bit c, input bit f);
    bit   ready;
    bit   dc;
    bit   da;
    bit   dr;
    int   h;
    exp_t e;
    @(negedge clk);
    alloc_         = ~a;
    alloc_pc       = apc;
    resolve_       = ~r;
    resolve_id     = rid[BQ-1:0];
    resolve_taken_ = ~rt;
    resolve_tar    = rtar;
    commit_        = ~c;
    flush_         = ~f;

    h     = m_head;
    ready = m_valid[h] && m_res[h];
    chk_eq("commit_ready", {63'd0, commit_ready}, {63'd0, ready});
    chk_eq("bq_full", {63'd0, bq_full}, {63'd0, (m_count == BQ_D)});
    chk_eq("alloc_id", 64'(alloc_id), 64'(m_tail));

    dc = c && ready;
    da = a && (m_count != BQ_D) && !f;
    dr = r && m_valid[rid] && !f;

    if (dc) begin
      e.taken = m_taken[h];
      e.pc    = m_pc[h];
      e.tar   = m_tar[h];
`ifdef BQ_TAKEN_ONLY_EN
      if (e.taken) sb_q.push_back(e);
`else
      sb_q.push_back(e);
`endif
    end
    if (dr) begin
      m_res[rid]   = 1'b1;
      m_taken[rid] = rt;
      m_tar[rid]   = rtar;
    end
    if (da) begin
      m_valid[m_tail] = 1'b1;
      m_res[m_tail]   = 1'b0;
      m_pc[m_tail]    = apc;
      m_tail          = (m_tail + 1) % BQ_D;
      m_count++;
    end
    if (dc) begin
      m_valid[h] = 1'b0;
      m_res[h]   = 1'b0;
      m_head     = (h + 1) % BQ_D;
      m_count--;
    end
    if (f) begin
      for (int i = 0; i < BQ_D; i++) begin
        m_valid[i] = 1'b0;
        m_res[i]   = 1'b0;
      end
      m_head  = 0;
      m_tail  = 0;
      m_count = 0;
    end

    @(posedge clk);
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk_eq("pulse", {63'd0, pc_chg_com_}, 64'd0);
      chk_eq("chg_taken_", {63'd0, chg_taken_}, {63'd0, ~e.taken});
      chk_eq("com_addr", 64'(com_addr), 64'(e.pc));
      chk_eq("com_tar_addr", 64'(com_tar_addr), 64'(e.tar));
      m_com_addr = e.pc;
      m_com_tar  = e.tar;
    end else begin
      chk_eq("no_pulse", {63'd0, pc_chg_com_}, 64'd1);
      chk_eq("com_addr_hold", 64'(com_addr), 64'(m_com_addr));
      chk_eq("com_tar_hold", 64'(com_tar_addr), 64'(m_com_tar));
    end
    drive_idle();
  endtask

  task automatic do_alloc(input logic [ADDR-1:0] pc);
    step(1'b1, pc, 1'b0, 0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic do_resolve(input int id, input bit t, input logic [ADDR-1:0] tar);
    step(1'b0, '0, 1'b1, id, t, tar, 1'b0, 1'b0);
  endtask

  task automatic do_commit();
    step(1'b0, '0, 1'b0, 0, 1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic do_idle();
    step(1'b0, '0, 1'b0, 0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic do_flush();
    step(1'b0, '0, 1'b0, 0, 1'b0, '0, 1'b0, 1'b1);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    drive_idle();
    model_reset();
    reset_ = 1'b0;
    #12;
    chk_eq("rst_pulse", {63'd0, pc_chg_com_}, 64'd1);
    chk_eq("rst_taken", {63'd0, chg_taken_}, 64'd1);
    chk_eq("rst_com_addr", 64'(com_addr), 64'd0);
    chk_eq("rst_com_tar", 64'(com_tar_addr), 64'd0);
    chk_eq("rst_full", {63'd0, bq_full}, 64'd0);
    chk_eq("rst_ready", {63'd0, commit_ready}, 64'd0);
    chk_eq("rst_alloc_id", 64'(alloc_id), 64'd0);
    @(negedge clk);
    reset_ = 1'b1;

    // Basic alloc / resolve / commit, plus a resolve to an invalid entry.
    do_resolve(5, 1'b1, 32'h0000_5555);
    do_alloc(32'hdeadbe74);
    do_resolve(0, 1'b1, 32'hcafecafe);
    do_commit();
    do_idle();
    do_idle();

    // Out-of-order resolution with commit held low.
    do_flush();
    do_alloc(32'h0000_1000);
    do_alloc(32'h0000_1004);
    do_alloc(32'h0000_1008);
    do_resolve(2, 1'b0, 32'h0000_2008);
    do_resolve(1, 1'b1, 32'h0000_2004);
    do_commit();
    do_commit();
    step(1'b0, '0, 1'b1, 0, 1'b1, 32'h0000_2000, 1'b1, 1'b0);
    do_commit();
    do_commit();
    do_commit();
    do_idle();

    // Fill, overflow attempt, wrap and id reuse.
    do_flush();
    for (int i = 0; i < BQ_D; i++) do_alloc(32'h0000_4000 + 32'(i * 4));
    do_alloc(32'h0000_BAD0);
    do_resolve(0, 1'b1, 32'h0000_8000);
    step(1'b1, 32'h0000_BAD4, 1'b0, 0, 1'b0, '0, 1'b1, 1'b0);
    do_alloc(32'h0000_5000);
    do_idle();

    // Not-taken commit; alloc with commit when not full.
    do_resolve(1, 1'b1, 32'h0000_8004);
    do_resolve(2, 1'b1, 32'h0000_8008);
    do_resolve(3, 1'b0, 32'h0000_1000);
    do_resolve(2, 1'b0, 32'h0000_9008);
    do_commit();
    step(1'b1, 32'h0000_6000, 1'b0, 0, 1'b0, '0, 1'b1, 1'b0);
    do_commit();
    do_idle();

    // Commit and flush together with four valid entries.
    do_flush();
    for (int i = 0; i < 4; i++) do_alloc(32'h0000_7000 + 32'(i * 4));
    do_resolve(0, 1'b1, 32'h0000_7700);
    step(1'b0, '0, 1'b0, 0, 1'b0, '0, 1'b1, 1'b1);
    do_idle();

    // Asynchronous reset in the middle of a training pulse.
    do_alloc(32'h0000_abc0);
    do_resolve(0, 1'b1, 32'h0000_abcc);
    do_commit();
    #1;
    reset_ = 1'b0;
    #1;
    chk_eq("arst_pulse", {63'd0, pc_chg_com_}, 64'd1);
    chk_eq("arst_com_addr", 64'(com_addr), 64'd0);
    chk_eq("arst_full", {63'd0, bq_full}, 64'd0);
    model_reset();
    @(negedge clk);
    reset_ = 1'b1;
    do_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/br_com_queue.md
Name: br_com_queue

Overview:
- In-order branch commit queue that produces the BTB training interface (pc_chg_com_, chg_taken_, com_addr, com_tar_addr).
- Decode allocates one entry per branch in program order.
- Execute resolves entries out of order by id.
- At retirement the ROB pops the oldest resolved entry, and the block emits a one-cycle registered training pulse to the BTB.

Parameters:
- ADDR, 32, address width of PC and target.
- BQ_D, 8, queue depth; power of two, at least 2.
- BQ, 3, entry id width; log2(BQ_D).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset_  in  1  asynchronous active-low reset.
- alloc_  in  1  active-low: allocate the tail entry for a new branch.
- alloc_pc  in  ADDR  PC of the allocating branch.
- alloc_id  out  BQ  id of the current tail; combinational from the tail pointer.
- bq_full  out  1  high when count == BQ_D.
- resolve_  in  1  active-low: branch resolution valid.
- resolve_id  in  BQ  entry being resolved.
- resolve_taken_  in  1  active-low: branch taken.
- resolve_tar  in  ADDR  resolved target address.
- commit_  in  1  active-low: ROB retires the oldest branch.
- commit_ready  out  1  high when the head entry is valid and resolved (registered state only).
- flush_  in  1  active-low: discard all entries.
- pc_chg_com_  out  1  active-low training strobe to the BTB.
- chg_taken_  out  1  active-low taken flag to the BTB.
- com_addr  out  ADDR  committed branch PC.
- com_tar_addr  out  ADDR  committed branch target.

Behaviour:
- Per-entry state: valid, resolved, taken, pc, tar.
- Queue state: head pointer (BQ bits), tail pointer (BQ bits), count (BQ+1 bits). Pointers wrap modulo BQ_D.
- Reset values:
  - All entries invalid; head = tail = count = 0.
  - pc_chg_com_ = 1 and chg_taken_ = 1 (both disabled).
  - com_addr = 0, com_tar_addr = 0, bq_full = 0, commit_ready = 0, alloc_id = 0.
- Allocate (alloc_ low and bq_full low):
  - Entry[tail] gets valid=1, resolved=0, pc=alloc_pc.
  - tail+1, count+1.
  - alloc_ while full is ignored, with no state change.
  - Full is judged on the registered count, so alloc is rejected even if a commit frees an entry in the same cycle.
- Resolve (resolve_ low):
  - If entry[resolve_id] is valid: resolved=1, taken=!resolve_taken_, tar=resolve_tar.
  - A resolve to an invalid entry is ignored.
  - A re-resolve of an already-resolved entry overwrites it (last write wins).
- Commit (commit_ low and commit_ready high):
  - Entry[head] is cleared; head+1, count-1.
  - Next cycle: pc_chg_com_=0, chg_taken_=!taken, com_addr=pc, com_tar_addr=tar. Latency is exactly 1 cycle.
  - On the following cycle pc_chg_com_ returns to 1. com_addr and com_tar_addr hold their last value.
  - commit_ while commit_ready is low is ignored; no pulse is emitted.
- Resolve and commit on the same head entry in the same cycle: commit_ready reflects registered state, so the commit is not taken that cycle.
- Alloc and commit in the same cycle (not full): both are performed and count is unchanged.
- Flush (flush_ low):
  - Clears all valid bits; head = tail = count = 0.
  - Alloc and resolve in the same cycle are ignored.
  - A commit in the same cycle still produces its training pulse next cycle.
- Back-to-back commits produce pulses on consecutive cycles.
- Wrap: after BQ_D allocations, tail returns to 0; ids are reused only after the previous occupant has committed or been flushed.

Optional Feature:
- Macro: BQ_TAKEN_ONLY_EN.
- Defined: commits of not-taken branches still pop the queue but do not assert pc_chg_com_; only taken branches train the BTB, which reduces BTB write traffic.
- Undefined: every commit pulses pc_chg_com_, with chg_taken_ carrying the direction.

Test Plan:
- Reset, then alloc pc=32'hdeadbe74 (id 0); resolve id 0 taken, tar=32'hcafecafe; commit -> next cycle pc_chg_com_=0, chg_taken_=0, com_addr=deadbe74, com_tar_addr=cafecafe; one-cycle pulse; commit_ready=0 afterwards.
- Alloc ids 0,1,2; resolve 2 then 1; commit held low -> no pulse until id 0 is resolved; then pulses for ids 0,1,2 on consecutive cycles in order.
- Alloc 8 entries -> bq_full=1; 9th alloc ignored (tail stays 0); commit head, then alloc -> alloc_id 0 reused; count stays 8.
- Resolve id 3 not-taken, tar=32'h1000, then commit -> chg_taken_=1, pc_chg_com_=0 (macro off); with BQ_TAKEN_ONLY_EN the pop occurs, pc_chg_com_ stays 1, and commit_ready advances.
- 4 entries valid, commit and flush in the same cycle -> one training pulse next cycle; count=0, commit_ready=0, alloc_id=0.
- Assert reset_ low mid-pulse -> pc_chg_com_=1, com_addr=0, bq_full=0 immediately (asynchronous).
